// File: rtl/dff_bank_scheduler.sv
// Round-robin scheduler that shares one DFF register bank between NREQ requesters,
// issuing one single-cycle load/set/clear/toggle strobe per grant followed by an ack.
module dff_bank_scheduler #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [2*NREQ-1:0]     op,
    input  logic [WIDTH*NREQ-1:0] wdata,
    input  logic [WIDTH-1:0]      bank_q,
    output logic [NREQ-1:0]       grant,
    output logic [NREQ-1:0]       ack,
    output logic                  busy,
    output logic [WIDTH-1:0]      bank_d,
    output logic                  bank_we,
    output logic                  bank_set,
    output logic                  bank_reset_n
);
    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_SET  = 2'b01;
    localparam logic [1:0] OP_CLR  = 2'b10;
    localparam logic [1:0] OP_TGL  = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        ACK   = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic [PTR_W-1:0]   ptr_r;
    logic [PTR_W-1:0]   idx_r;
    logic [1:0]         op_r;
    logic [WIDTH-1:0]   wdata_r;
    logic [WIDTH-1:0]   snap_r;

    logic [PTR_W-1:0]   cand_s;
    logic [PTR_W-1:0]   sel_s;
    logic               sel_vld_s;

    logic [NREQ-1:0]    grant_r, grant_nxt_s;
    logic [NREQ-1:0]    ack_r, ack_nxt_s;
    logic               busy_r, busy_nxt_s;
    logic [WIDTH-1:0]   bank_d_r, bank_d_nxt_s;
    logic               bank_we_r, bank_we_nxt_s;
    logic               bank_set_r, bank_set_nxt_s;
    logic               bank_reset_n_r, bank_reset_n_nxt_s;

    // Increment modulo NREQ; non-power-of-two NREQ needs the explicit wrap.
    function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] v);
        if (v == PTR_W'(NREQ - 1)) begin
            return {PTR_W{1'b0}};
        end else begin
            return v + PTR_W'(1);
        end
    endfunction

    function automatic logic [NREQ-1:0] to_onehot(input logic [PTR_W-1:0] v);
        logic [NREQ-1:0] r;
        r    = {NREQ{1'b0}};
        r[v] = 1'b1;
        return r;
    endfunction

    // Round-robin search: first set req bit at or above ptr, wrapping.
    always_comb begin
        cand_s    = ptr_r;
        sel_s     = ptr_r;
        sel_vld_s = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            sel_s     = (req[cand_s] && !sel_vld_s) ? cand_s : sel_s;
            sel_vld_s = sel_vld_s | req[cand_s];
            cand_s    = wrap_inc(cand_s);
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE:    state_nxt_s = sel_vld_s ? APPLY : IDLE;
            APPLY:   state_nxt_s = ACK;
            ACK:     state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Output decode; every output is captured in a register on the next edge.
    always_comb begin
        grant_nxt_s        = grant_r;
        ack_nxt_s          = {NREQ{1'b0}};
        busy_nxt_s         = 1'b0;
        bank_d_nxt_s       = {WIDTH{1'b0}};
        bank_we_nxt_s      = 1'b0;
        bank_set_nxt_s     = 1'b0;
        bank_reset_n_nxt_s = 1'b1;
        case (state_r)
            IDLE: begin
                grant_nxt_s = sel_vld_s ? to_onehot(sel_s) : {NREQ{1'b0}};
            end
            APPLY: begin
                busy_nxt_s = 1'b1;
                case (op_r)
                    OP_LOAD: begin
                        bank_we_nxt_s = 1'b1;
                        bank_d_nxt_s  = wdata_r;
                    end
                    OP_SET: begin
                        bank_we_nxt_s  = 1'b1;
                        bank_set_nxt_s = 1'b1;
                        bank_d_nxt_s   = {WIDTH{1'b1}};
                    end
                    OP_CLR: begin
                        bank_reset_n_nxt_s = 1'b0;
                    end
                    OP_TGL: begin
                        bank_we_nxt_s = 1'b1;
                        bank_d_nxt_s  = ~snap_r;
                    end
                    default: begin
                        bank_reset_n_nxt_s = 1'b1;
                    end
                endcase
            end
            ACK: begin
                busy_nxt_s = 1'b1;
                ack_nxt_s  = to_onehot(idx_r);
            end
            default: begin
                grant_nxt_s = {NREQ{1'b0}};
            end
        endcase
    end

    // Output registers; reset holds the bank clear low.
    always_ff @(posedge clk) begin
        if (reset) begin
            grant_r        <= {NREQ{1'b0}};
            ack_r          <= {NREQ{1'b0}};
            busy_r         <= 1'b0;
            bank_d_r       <= {WIDTH{1'b0}};
            bank_we_r      <= 1'b0;
            bank_set_r     <= 1'b0;
            bank_reset_n_r <= 1'b0;
        end else begin
            grant_r        <= grant_nxt_s;
            ack_r          <= ack_nxt_s;
            busy_r         <= busy_nxt_s;
            bank_d_r       <= bank_d_nxt_s;
            bank_we_r      <= bank_we_nxt_s;
            bank_set_r     <= bank_set_nxt_s;
            bank_reset_n_r <= bank_reset_n_nxt_s;
        end
    end

    // Transaction latch at grant time, plus pointer advance once the owner is acked.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_r   <= {PTR_W{1'b0}};
            idx_r   <= {PTR_W{1'b0}};
            op_r    <= 2'b00;
            wdata_r <= {WIDTH{1'b0}};
            snap_r  <= {WIDTH{1'b0}};
        end else if ((state_r == IDLE) && sel_vld_s) begin
            idx_r   <= sel_s;
            op_r    <= op[2*int'(sel_s) +: 2];
            wdata_r <= wdata[WIDTH*int'(sel_s) +: WIDTH];
            snap_r  <= bank_q;
        end else if (state_r == ACK) begin
            ptr_r   <= wrap_inc(idx_r);
        end else begin
            ptr_r   <= ptr_r;
        end
    end

    assign grant        = grant_r;
    assign ack          = ack_r;
    assign busy         = busy_r;
    assign bank_d       = bank_d_r;
    assign bank_we      = bank_we_r;
    assign bank_set     = bank_set_r;
    assign bank_reset_n = bank_reset_n_r;

endmodule

// File: tb/tb_dff_bank_scheduler.sv
// Directed bench for dff_bank_scheduler: table of single transactions plus
// hand-written sequences for fairness, late requests, mid-op reset and withdrawal.
module tb_dff_bank_scheduler;
    localparam int WIDTH = 8;
    localparam int NREQ  = 4;

    logic                  clk;
    logic                  reset;
    logic [NREQ-1:0]       req;
    logic [2*NREQ-1:0]     op;
    logic [WIDTH*NREQ-1:0] wdata;
    logic [WIDTH-1:0]      bank_q;
    logic [NREQ-1:0]       grant;
    logic [NREQ-1:0]       ack;
    logic                  busy;
    logic [WIDTH-1:0]      bank_d;
    logic                  bank_we;
    logic                  bank_set;
    logic                  bank_reset_n;

    int errors = 0;
    int checks = 0;

    dff_bank_scheduler #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
        .clk(clk), .reset(reset), .req(req), .op(op), .wdata(wdata),
        .bank_q(bank_q), .grant(grant), .ack(ack), .busy(busy),
        .bank_d(bank_d), .bank_we(bank_we), .bank_set(bank_set),
        .bank_reset_n(bank_reset_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural bank: clear dominates, set loads all ones with we.
    always @(posedge clk) begin
        if (!bank_reset_n)  bank_q <= 8'h00;
        else if (bank_we)   bank_q <= bank_set ? 8'hFF : bank_d;
    end

    typedef struct {
        int         idx;
        logic [1:0] o;
        logic [7:0] wd;
        logic [7:0] exp_d;
        logic       exp_we;
        logic       exp_set;
        logic       exp_rn;
        logic [7:0] exp_bank;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = 4'b0000;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // One complete transaction from an idle scheduler, checked cycle by cycle.
    task automatic run_txn(input vec_t v);
        logic [3:0] g;
        g = 4'b0001 << v.idx;
        op[2*v.idx +: 2]    = v.o;
        wdata[8*v.idx +: 8] = v.wd;
        req[v.idx]          = 1'b1;
        tick();
        chk("txn_grant", grant, g);
        chk("txn_busy_idle", busy, 1'b0);
        chk("txn_we_early", bank_we, 1'b0);
        tick();
        chk("txn_we", bank_we, v.exp_we);
        chk("txn_set", bank_set, v.exp_set);
        chk("txn_rn", bank_reset_n, v.exp_rn);
        chk("txn_d", bank_d, v.exp_d);
        chk("txn_busy", busy, 1'b1);
        chk("txn_ack_early", ack, 4'b0000);
        tick();
        chk("txn_ack", ack, g);
        chk("txn_grant_hold", grant, g);
        chk("txn_strobe_off", {bank_we, bank_set, bank_reset_n}, 3'b001);
        chk("txn_bank", bank_q, v.exp_bank);
        req[v.idx] = 1'b0;
        tick();
        chk("txn_grant_clr", grant, 4'b0000);
        chk("txn_ack_clr", ack, 4'b0000);
        chk("txn_busy_clr", busy, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [3:0] eg;
        reset = 1'b1;
        req   = 4'b0000;
        op    = 8'h00;
        wdata = 32'h0;

        vecs[0] = '{2, 2'b00, 8'hA5, 8'hA5, 1'b1, 1'b0, 1'b1, 8'hA5};
        vecs[1] = '{1, 2'b01, 8'h00, 8'hFF, 1'b1, 1'b1, 1'b1, 8'hFF};
        vecs[2] = '{1, 2'b10, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[3] = '{1, 2'b00, 8'h0F, 8'h0F, 1'b1, 1'b0, 1'b1, 8'h0F};
        vecs[4] = '{1, 2'b11, 8'h00, 8'hF0, 1'b1, 1'b0, 1'b1, 8'hF0};
        vecs[5] = '{0, 2'b11, 8'h00, 8'h0F, 1'b1, 1'b0, 1'b1, 8'h0F};
        vecs[6] = '{3, 2'b10, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[7] = '{2, 2'b00, 8'h5A, 8'h5A, 1'b1, 1'b0, 1'b1, 8'h5A};

        // Reset state.
        tick();
        tick();
        chk("rst_grant", grant, 4'b0000);
        chk("rst_ack", ack, 4'b0000);
        chk("rst_busy", busy, 1'b0);
        chk("rst_we", bank_we, 1'b0);
        chk("rst_set", bank_set, 1'b0);
        chk("rst_d", bank_d, 8'h00);
        chk("rst_rn", bank_reset_n, 1'b0);
        chk("rst_bank", bank_q, 8'h00);
        reset = 1'b0;
        tick();
        chk("rst_rn_release", bank_reset_n, 1'b1);

        for (int i = 0; i < 8; i++) run_txn(vecs[i]);

        // Mid-operation reset; ptr is 3 here, so a surviving ptr would favour req[3].
        op[3:2] = 2'b00; wdata[15:8] = 8'h3C; req[1] = 1'b1;
        tick();
        chk("mrst_grant", grant, 4'b0010);
        reset = 1'b1;
        op[7:6] = 2'b00; wdata[31:24] = 8'hC3; req[3] = 1'b1;
        tick();
        chk("mrst_we", bank_we, 1'b0);
        chk("mrst_rn", bank_reset_n, 1'b0);
        chk("mrst_grant0", grant, 4'b0000);
        chk("mrst_ack0", ack, 4'b0000);
        tick();
        chk("mrst_bank", bank_q, 8'h00);
        chk("mrst_ack1", ack, 4'b0000);
        reset = 1'b0;
        tick();
        chk("mrst_regrant", grant, 4'b0010);
        chk("mrst_rn_up", bank_reset_n, 1'b1);
        tick();
        chk("mrst_load_d", bank_d, 8'h3C);
        tick();
        chk("mrst_ack", ack, 4'b0010);
        chk("mrst_bank_3c", bank_q, 8'h3C);
        req[1] = 1'b0;
        tick();
        chk("mrst_next_grant", grant, 4'b1000);
        tick();
        tick();
        chk("mrst_ack3", ack, 4'b1000);
        chk("mrst_bank_c3", bank_q, 8'hC3);
        req[3] = 1'b0;
        tick();
        chk("mrst_idle", grant, 4'b0000);

        // Request withdrawn after one cycle still completes.
        op[3:2] = 2'b01; req[1] = 1'b1;
        tick();
        chk("wd_grant", grant, 4'b0010);
        req[1] = 1'b0; op[3:2] = 2'b00;
        tick();
        chk("wd_set", {bank_we, bank_set, bank_d}, {1'b1, 1'b1, 8'hFF});
        tick();
        chk("wd_ack", ack, 4'b0010);
        chk("wd_bank", bank_q, 8'hFF);
        tick();
        chk("wd_ack_once", ack, 4'b0000);
        tick();
        chk("wd_ack_once2", ack, 4'b0000);
        chk("wd_grant_clr", grant, 4'b0000);

        // Round-robin fairness with all four requesting continuously.
        do_reset();
        op = 8'h00; wdata = 32'h44332211; req = 4'b1111;
        for (int c = 0; c < 18; c++) begin
            tick();
            eg = 4'b0001 << ((c / 3) % 4);
            chk("rr_grant", grant, eg);
            chk("rr_ack", ack, ((c % 3) == 2) ? eg : 4'b0000);
        end
        req = 4'b0000;
        tick();
        chk("rr_idle", grant, 4'b0000);

        // Late request during APPLY, then ptr-ordered tie break.
        do_reset();
        req = 4'b1000;
        tick();
        chk("late_g3", grant, 4'b1000);
        tick();
        req[0] = 1'b1;
        tick();
        chk("late_ack3", ack, 4'b1000);
        req[3] = 1'b0;
        tick();
        chk("late_g0", grant, 4'b0001);
        tick();
        tick();
        chk("late_ack0", ack, 4'b0001);
        req[0] = 1'b0; req[3] = 1'b1; req[1] = 1'b1;
        tick();
        chk("late_g1", grant, 4'b0010);
        tick();
        tick();
        chk("late_ack1", ack, 4'b0010);
        req[1] = 1'b0;
        tick();
        chk("late_g3b", grant, 4'b1000);
        tick();
        tick();
        chk("late_ack3b", ack, 4'b1000);
        req[3] = 1'b0;
        tick();
        chk("late_idle", grant, 4'b0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
